fifo_axi_burst_wr: RTL and testbench
====================================

// Module: fifo_axi_burst_wr
// PURPOSE
//  Drains the read port of the video async FIFO (first-word fall-through) and writes the pixel stream to DDR.
//  Writes use fixed-length AXI4 INCR bursts into a frame buffer that wraps.
//  Sits in the DDR (read) clock domain between the async FIFO and the memory-controller AXI slave port.
// PARAMETERS
//  DSIZE       128      FIFO/AXI data width in bits; power of 2, >= 8
//  AWIDTH      32       AXI address width
//  BURST_LEN   16       beats per burst, 1..256; BURST_LEN*DSIZE/8 must divide 4096
//  FRAME_BYTES 8294400  frame buffer size in bytes; must be a multiple of burst bytes
// PORTS
//  rclk           in   1           DDR/AXI clock
//  rrst_n         in   1           async active-low reset
//  fifo_rdata     in   DSIZE       FWFT data, valid whenever !fifo_rempty
//  fifo_rempty    in   1           FIFO empty
//  fifo_rinc      out  1           pop strobe
//  cfg_base_addr  in   AWIDTH      frame buffer base, burst-aligned; sampled at frame start
//  frame_sync     in   1           1-cycle pulse: next burst restarts at base
//  m_awaddr       out  AWIDTH      burst address
//  m_awlen        out  8           BURST_LEN-1 (constant)
//  m_awsize       out  3           log2(DSIZE/8) (constant)
//  m_awburst      out  2           2'b01 INCR (constant)
//  m_awvalid/m_awready  out/in 1   AW handshake
//  m_wdata        out  DSIZE       = fifo_rdata
//  m_wstrb        out  DSIZE/8     all ones
//  m_wlast        out  1           asserted on beat BURST_LEN-1
//  m_wvalid/m_wready    out/in 1   W handshake
//  m_bresp        in   2           write response
//  m_bvalid/m_bready    in/out 1   B handshake
//  busy           out  1           state != IDLE
//  wr_err         out  1           sticky: set when any bresp != OKAY; cleared by reset only
// BEHAVIOUR
//  Reset: state IDLE, offset 0, awvalid/wvalid/bready/fifo_rinc/busy/wr_err = 0, beat counter 0.
//  FSM IDLE->AW: when !fifo_rempty; awaddr = base_q + offset is registered on this transition.
//  AW: awvalid held until awready; AW->W on the handshake; the address does not change while valid.
//  W: wvalid = !fifo_rempty (combinational); fifo_rinc = wvalid & wready.
//   Beat counter increments per handshake; wlast = (cnt == BURST_LEN-1).
//   A handshake with wlast moves W->B.
//  B: bready = 1; on bvalid the FSM returns to IDLE and sets wr_err if bresp != 2'b00.
//   offset += BURST_LEN*DSIZE/8; when the result equals FRAME_BYTES, offset becomes 0.
//  Throughput: one burst is outstanding at a time. Minimum per burst is BURST_LEN+3 cycles (IDLE, AW, W beats, B).
//  FIFO empty mid-burst: wvalid drops (legal AXI); the burst resumes when data returns, with no beat lost or duplicated.
//  frame_sync is latched into sync_pend. At the next IDLE->AW transition: base_q = cfg_base_addr, offset = 0, sync_pend cleared.
//   A burst already in progress completes at its old address.
//  frame_sync coincident with IDLE->AW applies to that same burst.
//  wready and awready may be low indefinitely; no timeout.
//  The frame size is a multiple of the burst size, so no partial bursts are issued.
//  Async reset mid-burst abandons the AXI transaction. The memory side must be reset together with this block.
// CONFIGURATION
//  `FIFO_AXI_BURST_WR_STAT_EN defined: adds output stat_bursts[15:0].
//   It counts completed B responses and clears to 0 when a frame_sync is applied. It saturates at 16'hFFFF.
//  Undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package video_ddr_pkg: FSM state enum {IDLE, AW, W, B}, AXI_BURST_INCR, AXI_RESP_OKAY constants,
//   and a clog2 helper for m_awsize.
//  Single flat module; no sub-module required. The async FIFO is instanced beside it by the parent.
// TESTING
//  Parameters for the bench: DSIZE=128, BURST_LEN=4, FRAME_BYTES=256, base 0x1000.
//  1 Preload 4 words, ready always 1.
//   -> one AW @0x1000 with awlen=3, awsize=4; 4 beats with wlast on the 4th; 4 pops; busy low after B.
//  2 Feed 16 words (4 bursts).
//   -> addresses 0x1000, 0x1040, 0x1080, 0x10C0; the 5th burst is at 0x1000 (wrap).
//  3 Make the FIFO empty after beat 2 for 5 cycles and toggle wready randomly.
//   -> wdata sequence equals the FIFO input order; exactly 4 beats; no pop while wvalid=0.
//  4 Pulse frame_sync during beat 1 of the burst at 0x1040, with cfg_base_addr=0x8000.
//   -> that burst finishes at 0x1040; the next AW is @0x8000.
//  5 Return bresp=2'b10 on burst 2.
//   -> wr_err=1 from the B handshake and stays 1. With STAT_EN, stat_bursts counts 1,2,3 and resets after frame_sync.
//  6 Assert rrst_n low during state W.
//   -> all outputs are 0 immediately; after release, the first AW is @base with offset 0.

Source files
------------

// File: rtl/video_ddr_pkg.sv
// Shared definitions for the video-to-DDR write path: FSM states, AXI encodings
// and a constant log2 helper used to derive AXI size fields.
package video_ddr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    AW,
    W,
    B
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Ceiling log2 of a constant; used for elaboration-time field values only.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_axi_burst_wr_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst writer and the
// memory-controller slave port.
interface fifo_axi_burst_wr_if #(
  parameter int unsigned DSIZE  = 128,
  parameter int unsigned AWIDTH = 32
);

  logic [AWIDTH-1:0]  awaddr;
  logic [7:0]         awlen;
  logic [2:0]         awsize;
  logic [1:0]         awburst;
  logic               awvalid;
  logic               awready;
  logic [DSIZE-1:0]   wdata;
  logic [DSIZE/8-1:0] wstrb;
  logic               wlast;
  logic               wvalid;
  logic               wready;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/fifo_axi_burst_wr.sv
// fifo_axi_burst_wr: drains a first-word-fall-through FIFO into fixed-length
// AXI4 INCR write bursts over a wrapping frame buffer, one burst outstanding.
// Optional feature macro: FIFO_AXI_BURST_WR_STAT_EN adds stat_bursts[15:0],
// a saturating count of completed B responses cleared when a frame_sync applies.
module fifo_axi_burst_wr
  import video_ddr_pkg::*;
#(
  parameter int unsigned DSIZE       = 128,
  parameter int unsigned AWIDTH      = 32,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned FRAME_BYTES = 8294400
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic [DSIZE-1:0]  fifo_rdata,
  input  logic              fifo_rempty,
  output logic              fifo_rinc,
  input  logic [AWIDTH-1:0] cfg_base_addr,
  input  logic              frame_sync,
  fifo_axi_burst_wr_if.master m,
  output logic              busy,
  output logic              wr_err
`ifdef FIFO_AXI_BURST_WR_STAT_EN
  ,
  output logic [15:0]       stat_bursts
`endif
);

  localparam int unsigned       BURST_BYTES = BURST_LEN * DSIZE / 8;
  localparam logic [AWIDTH-1:0] OFFSET_STEP = AWIDTH'(BURST_BYTES);
  localparam logic [AWIDTH-1:0] OFFSET_WRAP = AWIDTH'(FRAME_BYTES);
  localparam logic [7:0]        LAST_BEAT   = 8'(BURST_LEN - 1);

  wr_state_e         state, state_n;
  logic [AWIDTH-1:0] base_q;
  logic [AWIDTH-1:0] offset;
  logic [AWIDTH-1:0] offset_inc;
  logic [AWIDTH-1:0] awaddr_q;
  logic [7:0]        beat_cnt;
  logic              sync_pend;
  logic              sync_now;
  logic              start_burst;
  logic              w_hs;
  logic              b_hs;

  assign m.awaddr   = awaddr_q;
  assign m.awlen    = LAST_BEAT;
  assign m.awsize   = 3'(clog2(DSIZE / 8));
  assign m.awburst  = AXI_BURST_INCR;
  assign m.wdata    = fifo_rdata;
  assign m.wstrb    = '1;
  assign busy       = (state != IDLE);
  assign sync_now   = sync_pend | frame_sync;
  assign offset_inc = offset + OFFSET_STEP;

  // State register.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_n     = state;
    start_burst = 1'b0;
    w_hs        = 1'b0;
    b_hs        = 1'b0;
    fifo_rinc   = 1'b0;
    m.awvalid   = 1'b0;
    m.wvalid    = 1'b0;
    m.wlast     = 1'b0;
    m.bready    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_rempty) begin
          start_burst = 1'b1;
          state_n     = AW;
        end
      end
      AW: begin
        m.awvalid = 1'b1;
        if (m.awready) state_n = W;
      end
      W: begin
        m.wvalid  = !fifo_rempty;
        m.wlast   = (beat_cnt == LAST_BEAT);
        w_hs      = m.wvalid & m.wready;
        fifo_rinc = w_hs;
        if (w_hs && m.wlast) state_n = B;
      end
      B: begin
        m.bready = 1'b1;
        b_hs     = m.bvalid;
        if (m.bvalid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Burst address, frame offset and pending frame restart.
  // sync_pend comes out of reset set so the first burst samples cfg_base_addr.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      base_q    <= '0;
      offset    <= '0;
      awaddr_q  <= '0;
      sync_pend <= 1'b1;
    end else if (start_burst) begin
      if (sync_now) begin
        base_q    <= cfg_base_addr;
        offset    <= '0;
        awaddr_q  <= cfg_base_addr;
        sync_pend <= 1'b0;
      end else begin
        awaddr_q <= base_q + offset;
      end
    end else begin
      if (frame_sync) sync_pend <= 1'b1;
      if (b_hs)       offset    <= (offset_inc == OFFSET_WRAP) ? '0 : offset_inc;
    end
  end

  // Beat counter within the current burst.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)   beat_cnt <= '0;
    else if (w_hs) beat_cnt <= m.wlast ? '0 : beat_cnt + 8'd1;
  end

  // Sticky write-error flag.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)                               wr_err <= 1'b0;
    else if (b_hs && m.bresp != AXI_RESP_OKAY) wr_err <= 1'b1;
  end

`ifdef FIFO_AXI_BURST_WR_STAT_EN
  // Completed-burst counter, saturating, restarted with each applied frame_sync.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)                              stat_bursts <= '0;
    else if (start_burst && sync_now)         stat_bursts <= '0;
    else if (b_hs && stat_bursts != 16'hFFFF) stat_bursts <= stat_bursts + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_axi_burst_wr.sv
// Self-checking bench for fifo_axi_burst_wr: random ready/valid timing against a
// burst-level reference model (address = base + burst_index*64 mod frame, data in
// FIFO order, sticky error, optional burst counter).
module tb_fifo_axi_burst_wr;

  localparam int unsigned DSIZE       = 128;
  localparam int unsigned AWIDTH      = 32;
  localparam int unsigned BURST_LEN   = 4;
  localparam int unsigned FRAME_BYTES = 256;
  localparam int unsigned BURST_BYTES = BURST_LEN * DSIZE / 8;
  localparam logic [31:0] BASE        = 32'h1000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DSIZE-1:0]  fifo_rdata;
  logic              fifo_rempty;
  logic              fifo_rinc;
  logic [AWIDTH-1:0] cfg_base_addr;
  logic              frame_sync;
  logic              busy;
  logic              wr_err;
`ifdef FIFO_AXI_BURST_WR_STAT_EN
  logic [15:0]       stat_bursts;
`endif

  always #5 clk = ~clk;

  fifo_axi_burst_wr_if #(.DSIZE(DSIZE), .AWIDTH(AWIDTH)) axi ();

  fifo_axi_burst_wr #(
    .DSIZE(DSIZE),
    .AWIDTH(AWIDTH),
    .BURST_LEN(BURST_LEN),
    .FRAME_BYTES(FRAME_BYTES)
  ) dut (
    .rclk(clk),
    .rrst_n(rst_n),
    .fifo_rdata(fifo_rdata),
    .fifo_rempty(fifo_rempty),
    .fifo_rinc(fifo_rinc),
    .cfg_base_addr(cfg_base_addr),
    .frame_sync(frame_sync),
    .m(axi),
    .busy(busy),
    .wr_err(wr_err)
`ifdef FIFO_AXI_BURST_WR_STAT_EN
    ,
    .stat_bursts(stat_bursts)
`endif
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // FIFO contents and expected write-data order
  logic [DSIZE-1:0] fq[$];
  logic [DSIZE-1:0] sb[$];
  logic [31:0]      aw_log[$];

  // reference model
  logic [31:0] m_base = '0;
  logic [31:0] m_off = '0;
  logic [31:0] exp_addr = '0;
  bit          m_pend = 1'b1;
  bit          m_err = 1'b0;
  bit          in_burst = 1'b0;
  bit          aw_done = 1'b0;
  int unsigned beats = 0;
  int unsigned m_stat = 0;
  int          burst_idx = 0;

  // stimulus controls
  bit          rand_rdy = 1'b0;
  bit          stall_arm = 1'b0;
  bit          stall_req = 1'b0;
  int unsigned stall_cnt = 0;
  bit          sync_arm = 1'b0;
  logic [31:0] sync_addr = '0;
  logic [31:0] sync_cfg = '0;
  int          err_burst = -1;

  task automatic drive_fifo();
    fifo_rempty = (fq.size() == 0) || (stall_cnt != 0);
    fifo_rdata  = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push_words(input int n);
    logic [DSIZE-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      fq.push_back(w);
      sb.push_back(w);
    end
    drive_fifo();
  endtask

  // One clock: check at negedge, let the edge happen, update stimulus at posedge+1.
  task automatic step();
    bit aw_hs, w_hs, b_hs;
    @(negedge clk);
    if (axi.awvalid && !in_burst) begin
      in_burst = 1'b1;
      aw_done  = 1'b0;
      beats    = 0;
      if (m_pend) begin
        m_base = cfg_base_addr;
        m_off  = '0;
        m_pend = 1'b0;
        m_stat = 0;
      end
      exp_addr = m_base + m_off;
      aw_log.push_back(axi.awaddr);
    end
    check("busy", busy, in_burst);
    check("wr_err", wr_err, m_err);
`ifdef FIFO_AXI_BURST_WR_STAT_EN
    check("stat_bursts", stat_bursts, m_stat);
`endif
    check("awvalid", axi.awvalid, in_burst && !aw_done);
    if (axi.awvalid) begin
      check("awaddr", axi.awaddr, exp_addr);
      check("awlen", axi.awlen, BURST_LEN - 1);
      check("awsize", axi.awsize, 3'd4);
      check("awburst", axi.awburst, 2'b01);
    end
    check("wvalid", axi.wvalid, in_burst && aw_done && beats < BURST_LEN && !fifo_rempty);
    check("bready", axi.bready, in_burst && beats == BURST_LEN);
    check("fifo_rinc", fifo_rinc, axi.wvalid && axi.wready);
    aw_hs = axi.awvalid && axi.awready;
    w_hs  = axi.wvalid && axi.wready;
    b_hs  = axi.bvalid && axi.bready;
    if (w_hs) begin
      if (sb.size() == 0) check("wdata_extra_beat", 1'b1, 1'b0);
      else                check("wdata", axi.wdata, sb.pop_front());
      check("wlast", axi.wlast, beats == BURST_LEN - 1);
      check("wstrb", axi.wstrb, {(DSIZE/8){1'b1}});
      beats++;
      if (stall_arm && beats == 2) begin
        stall_req = 1'b1;
        stall_arm = 1'b0;
      end
    end
    if (aw_hs) aw_done = 1'b1;
    if (b_hs) begin
      if (axi.bresp != 2'b00) m_err = 1'b1;
      if (m_stat < 16'hFFFF) m_stat++;
      m_off    = (m_off + BURST_BYTES) % FRAME_BYTES;
      in_burst = 1'b0;
      burst_idx++;
    end
    @(posedge clk);
    if (frame_sync) m_pend = 1'b1;
    #1;
    if (w_hs) void'(fq.pop_front());
    if (stall_req) begin
      stall_cnt = 5;
      stall_req = 1'b0;
    end else if (stall_cnt != 0) begin
      stall_cnt--;
    end
    axi.awready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    axi.wready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    if (b_hs) begin
      axi.bvalid = 1'b0;
      axi.bresp  = 2'b00;
    end else if (in_burst && beats == BURST_LEN && !axi.bvalid &&
                 (!rand_rdy || $urandom_range(0, 1) == 1)) begin
      axi.bvalid = 1'b1;
      axi.bresp  = (burst_idx == err_burst) ? 2'b10 : 2'b00;
    end
    frame_sync = 1'b0;
    if (sync_arm && in_burst && exp_addr == sync_addr && beats == 1) begin
      frame_sync    = 1'b1;
      cfg_base_addr = sync_cfg;
      sync_arm      = 1'b0;
    end
    drive_fifo();
  endtask

  task automatic run_bursts(input int n, input int limit);
    int target;
    int cnt;
    target = burst_idx + n;
    cnt    = 0;
    while (burst_idx < target && cnt < limit) begin
      step();
      cnt++;
    end
    check("bursts_done", burst_idx, target);
  endtask

  initial begin
    int n;
    axi.awready   = 1'b1;
    axi.wready    = 1'b1;
    axi.bvalid    = 1'b0;
    axi.bresp     = 2'b00;
    frame_sync    = 1'b0;
    cfg_base_addr = BASE;
    push_words(4);
    repeat (2) step();
    rst_n = 1'b1;

    // 1: single burst, always ready
    run_bursts(1, 40);
    step();
    check("t1_idle_after_b", busy, 1'b0);
    check("t1_addr", aw_log[0], BASE);
    check("t1_fifo_drained", fq.size(), 0);

    // 2: four more bursts, address wraps after the frame
    push_words(16);
    run_bursts(4, 200);
    for (int i = 1; i < 5; i++)
      check("t2_addr_seq", aw_log[i], BASE + ((i % 4) * BURST_BYTES));

    // 3: FIFO empty mid-burst, random readies
    rand_rdy  = 1'b1;
    stall_arm = 1'b1;
    push_words(4);
    run_bursts(1, 200);
    check("t3_fifo_drained", fq.size(), 0);
    check("t3_all_beats", sb.size(), 0);

    // 4: frame_sync during the burst at 0x1040 moves the next burst to 0x8000
    sync_arm  = 1'b1;
    sync_addr = 32'h1040;
    sync_cfg  = 32'h8000;
    push_words(20);
    run_bursts(5, 600);
    check("t4_old_addr", aw_log[aw_log.size() - 2], 32'h1040);
    check("t4_new_addr", aw_log[aw_log.size() - 1], 32'h8000);

    // 5: error response on the second burst; later frame_sync back to BASE
    err_burst = burst_idx + 1;
    sync_arm  = 1'b1;
    sync_addr = 32'h80C0;
    sync_cfg  = BASE;
    push_words(16);
    run_bursts(4, 600);
    check("t5_err_sticky", wr_err, 1'b1);
    check("t5_resync_addr", aw_log[aw_log.size() - 1], BASE);

    // 6: reset while in W
    push_words(4);
    n = 0;
    while (!(in_burst && aw_done) && n < 100) begin
      step();
      n++;
    end
    check("t6_reached_w", in_burst && aw_done, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_awvalid", axi.awvalid, 1'b0);
    check("t6_rst_wvalid", axi.wvalid, 1'b0);
    check("t6_rst_wlast", axi.wlast, 1'b0);
    check("t6_rst_bready", axi.bready, 1'b0);
    check("t6_rst_rinc", fifo_rinc, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_wr_err", wr_err, 1'b0);
    in_burst   = 1'b0;
    aw_done    = 1'b0;
    beats      = 0;
    m_pend     = 1'b1;
    m_off      = '0;
    m_err      = 1'b0;
    m_stat     = 0;
    axi.bvalid = 1'b0;
    axi.bresp  = 2'b00;
    push_words(4);
    repeat (2) step();
    rst_n = 1'b1;
    run_bursts(1, 200);
    check("t6_addr_after_reset", aw_log[aw_log.size() - 1], BASE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
